mem_initiator: RTL

//  Initiator side of the single-port 16-bit program/data memory; owns addr/en_write/data_in, samples out.

---
 rtl/mem_initiator.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - single-port memory initiator arbitrating instruction fetch against load/store
module mem_initiator #(
  parameter int unsigned              ADDR_W   = 16,
  parameter int unsigned              DATA_W   = 16,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              mem_en_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  output logic [DATA_W-1:0] fetch_instr_o,
  output logic [ADDR_W-1:0] fetch_pc_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_done_o,
  output logic [DATA_W-1:0] ls_rdata_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              en_write_q, en_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              fvalid_q, fvalid_d;
  logic [DATA_W-1:0] finstr_q, finstr_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      en_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fvalid_q   <= 1'b0;
      finstr_q   <= '0;
      fpc_q      <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      en_write_q <= en_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fvalid_q   <= fvalid_d;
      finstr_q   <= finstr_d;
      fpc_q      <= fpc_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    en_write_d = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fvalid_d   = fvalid_q;
    finstr_d   = finstr_q;
    fpc_d      = fpc_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;

    if (fvalid_q && fetch_ready_i) begin
      fvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ls_req_i && !done_q) begin
          addr_d  = ls_addr_i;
          wdata_d = ls_wdata_i;
          if (ls_we_i) begin
            state_d    = STORE;
            en_write_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else if (!redirect_i && (!fvalid_q || fetch_ready_i)) begin
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = IDLE;
        // A redirect in the same cycle makes the word stale; drop it and keep pc for the redirect.
        if (!redirect_i) begin
          finstr_d = mem_rdata_i;
          fpc_d    = addr_q;
          fvalid_d = 1'b1;
          pc_d     = pc_q + PC_STEP;
        end
      end
      LOAD: begin
        state_d = IDLE;
        rdata_d = mem_rdata_i;
        done_d  = 1'b1;
      end
      STORE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_i) begin
      pc_d     = redirect_pc_i;
      fvalid_d = 1'b0;
    end
  end

  assign mem_en_write_o = en_write_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign fetch_valid_o  = fvalid_q;
  assign fetch_instr_o  = finstr_q;
  assign fetch_pc_o     = fpc_q;
  assign ls_done_o      = done_q;
  assign ls_rdata_o     = rdata_q;

endmodule
